// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB into TLB array and CSR strobes,
// then requests a fetch-again so younger instructions see the new translation state.
module tlb_op_ctrl #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_type,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  input  logic                  flush_in,
  input  logic [TLBNUMSIZE-1:0] csr_tlbidx,
  input  logic                  srch_hit,
  input  logic [TLBNUMSIZE-1:0] srch_index,
  output logic                  srch_go,
  output logic                  rd_go,
  output logic                  csr_s1e,
  output logic [TLBNUMSIZE-1:0] csr_s1_index,
  output logic                  csr_s1_ne,
  output logic                  csr_re,
  output logic                  tlb_we,
  output logic [TLBNUMSIZE-1:0] tlb_w_index,
  output logic                  inv_go,
  output logic [4:0]            f_op,
  output logic [9:0]            f_asid,
  output logic [18:0]           f_va,
  output logic                  refetch,
  output logic                  ine_exc,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, S_ISSUE, S_CAP, R_ISSUE, R_CAP, WRITE, INV, DONE} state_t;
  state_t state, state_n;
  logic [TLBNUMSIZE-1:0] fill_cnt, fill_idx;
  logic is_fill, ine_q, en, accept, legal;
  // strobes are also held off while reset is asserted so an aborted op emits nothing more
  assign en       = reset && !flush_in;
  assign op_ready = en && state == IDLE;
  assign accept   = op_valid && op_ready;
  assign legal    = op_type < 3'd4 || (op_type == 3'd4 && inv_op <= 5'd6);
  always_comb begin
    state_n = state;
    if (flush_in) state_n = IDLE;
    else case (state)
      IDLE:    state_n = !(accept && legal) ? IDLE :
                         op_type == 3'd0 ? S_ISSUE :
                         op_type == 3'd1 ? R_ISSUE :
                         op_type == 3'd4 ? INV : WRITE;
      S_ISSUE: state_n = S_CAP;
      S_CAP:   state_n = DONE;
      R_ISSUE: state_n = R_CAP;
      R_CAP:   state_n = DONE;
      WRITE:   state_n = DONE;
      INV:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      fill_idx <= '0;
      is_fill  <= 1'b0;
      ine_q    <= 1'b0;
      f_op     <= '0;
      f_asid   <= '0;
      f_va     <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_cnt == TLBNUMSIZE'(TLBNUM - 1) ? '0 : fill_cnt + 1'b1;
      ine_q    <= accept && !legal;
      if (accept) begin
        fill_idx <= fill_cnt;
        is_fill  <= op_type == 3'd3;
        f_op     <= inv_op;
        f_asid   <= inv_asid;
        f_va     <= inv_va;
      end
    end
  end
  assign srch_go      = en && state == S_ISSUE;
  assign rd_go        = en && state == R_ISSUE;
  assign csr_s1e      = en && state == S_CAP;
  assign csr_s1_index = csr_s1e ? srch_index : '0;
  assign csr_s1_ne    = csr_s1e && !srch_hit;
  assign csr_re       = en && state == R_CAP;
  assign tlb_we       = en && state == WRITE;
  assign tlb_w_index  = !tlb_we ? '0 : is_fill ? fill_idx : csr_tlbidx;
  assign inv_go       = en && state == INV;
  assign refetch      = en && state == DONE;
  assign ine_exc      = en && ine_q;
  assign busy         = state != IDLE;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed scenarios plus randomized op stream checked against a per-op timing model.
module tb_tlb_op_ctrl;
  logic clk = 0, reset = 0, op_valid = 0, flush_in = 0, srch_hit = 0;
  logic [2:0] op_type = 0;
  logic [4:0] inv_op = 0;
  logic [9:0] inv_asid = 0;
  logic [18:0] inv_va = 0;
  logic [3:0] csr_tlbidx = 0, srch_index = 0;
  logic op_ready, srch_go, rd_go, csr_s1e, csr_s1_ne, csr_re, tlb_we, inv_go, refetch, ine_exc, busy;
  logic [3:0] csr_s1_index, tlb_w_index;
  logic [4:0] f_op;
  logic [9:0] f_asid;
  logic [18:0] f_va;
  logic [9:0] sv;
  int checks = 0, errors = 0, model_cnt = 0;

  tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va), .flush_in(flush_in),
    .csr_tlbidx(csr_tlbidx), .srch_hit(srch_hit), .srch_index(srch_index), .srch_go(srch_go),
    .rd_go(rd_go), .csr_s1e(csr_s1e), .csr_s1_index(csr_s1_index), .csr_s1_ne(csr_s1_ne),
    .csr_re(csr_re), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .inv_go(inv_go), .f_op(f_op),
    .f_asid(f_asid), .f_va(f_va), .refetch(refetch), .ine_exc(ine_exc), .busy(busy)
  );

  always #5 clk = ~clk;
  // fill counter reference: cycles since reset release, modulo 16
  always @(posedge clk) model_cnt <= !reset ? 0 : (model_cnt + 1) % 16;
  // [9]srch_go [8]rd_go [7]csr_s1e [6]csr_re [5]tlb_we [4]inv_go [3]refetch [2]ine_exc [1]busy [0]op_ready
  assign sv = {srch_go, rd_go, csr_s1e, csr_re, tlb_we, inv_go, refetch, ine_exc, busy, op_ready};

  function automatic bit is_illegal(int op, int iop);
    return op > 4 || (op == 4 && iop > 6);
  endfunction

  function automatic int op_lat(int op, int iop);
    return is_illegal(op, iop) ? 1 : (op < 2 ? 3 : 2);
  endfunction

  // expected strobe vector k cycles after accept, while the bench keeps op_valid low only when idle
  function automatic logic [9:0] exp_sv(int op, int iop, int k);
    logic [9:0] v;
    int lat;
    v = '0;
    if (is_illegal(op, iop)) begin
      v[2] = k == 1;
      v[0] = 1'b1;
      return v;
    end
    lat = op_lat(op, iop);
    v[1] = k <= lat;
    v[3] = k == lat;
    if (k == 1) v[op == 0 ? 9 : op == 1 ? 8 : op == 4 ? 4 : 5] = 1'b1;
    if (k == 2 && op < 2) v[op == 0 ? 7 : 6] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    #1 checks++;
    if (sv[9:1] !== 9'b0 || csr_s1_index !== 0 || csr_s1_ne !== 0 || tlb_w_index !== 0 ||
        f_op !== 0 || f_asid !== 0 || f_va !== 0)
      begin errors++; $display("FAIL reset_state: got sv=%b idx=%0d ne=%b widx=%0d f=%0d/%0d/%0d want all zero",
        sv, csr_s1_index, csr_s1_ne, tlb_w_index, f_op, f_asid, f_va); end
    reset = 1;
  endtask

  task automatic test_srch();
    @(negedge clk); op_valid = 1; op_type = 0; srch_hit = 1; srch_index = 5;
    #1 checks++;
    if (op_ready !== 1) begin errors++; $display("FAIL srch_accept: op_ready=%b want 1", op_ready); end
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (sv !== 10'b1000000010) begin errors++; $display("FAIL srch_t1: sv=%b want 1000000010", sv); end
    @(negedge clk); #1 checks++;
    if (csr_s1e !== 1 || csr_s1_index !== 5 || csr_s1_ne !== 0)
      begin errors++; $display("FAIL srch_t2: s1e=%b idx=%0d ne=%b want 1 5 0", csr_s1e, csr_s1_index, csr_s1_ne); end
    @(negedge clk); #1 checks++;
    if (refetch !== 1 || busy !== 1) begin errors++; $display("FAIL srch_t3: refetch=%b busy=%b want 1 1", refetch, busy); end
    @(negedge clk); #1 checks++;
    if (op_ready !== 1 || busy !== 0 || refetch !== 0)
      begin errors++; $display("FAIL srch_t4: ready=%b busy=%b refetch=%b want 1 0 0", op_ready, busy, refetch); end
  endtask

  task automatic test_fill();
    int guard = 0;
    @(negedge clk);
    while (model_cnt != 14 && guard < 40) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 40) begin errors++; $display("FAIL fill_wait: fill counter never reached 14"); end
    op_valid = 1; op_type = 3; csr_tlbidx = 7;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (tlb_we !== 1 || tlb_w_index !== 14) begin errors++; $display("FAIL fill_idx14: we=%b idx=%0d want 1 14", tlb_we, tlb_w_index); end
    @(negedge clk); #1 checks++;
    if (refetch !== 1) begin errors++; $display("FAIL fill_refetch: refetch=%b want 1", refetch); end
    repeat (2) @(negedge clk);
    op_valid = 1; op_type = 3;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (tlb_we !== 1 || tlb_w_index !== 2) begin errors++; $display("FAIL fill_wrap: we=%b idx=%0d want 1 2", tlb_we, tlb_w_index); end
    @(negedge clk);
  endtask

  task automatic test_wr();
    @(negedge clk); op_valid = 1; op_type = 2; csr_tlbidx = 9;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (tlb_we !== 1 || tlb_w_index !== 9) begin errors++; $display("FAIL wr_index: we=%b idx=%0d want 1 9", tlb_we, tlb_w_index); end
    @(negedge clk); #1 checks++;
    if (refetch !== 1 || tlb_we !== 0) begin errors++; $display("FAIL wr_refetch: refetch=%b we=%b want 1 0", refetch, tlb_we); end
  endtask

  task automatic test_inv();
    @(negedge clk); op_valid = 1; op_type = 4; inv_op = 7;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (ine_exc !== 1 || inv_go !== 0 || refetch !== 0 || busy !== 0)
      begin errors++; $display("FAIL inv_illegal: ine=%b inv_go=%b refetch=%b busy=%b want 1 0 0 0", ine_exc, inv_go, refetch, busy); end
    @(negedge clk); #1 checks++;
    if (ine_exc !== 0 || refetch !== 0 || inv_go !== 0)
      begin errors++; $display("FAIL inv_illegal_t2: ine=%b refetch=%b inv_go=%b want 0 0 0", ine_exc, refetch, inv_go); end
    op_valid = 1; inv_op = 5; inv_asid = 10'h3A; inv_va = 19'h12345;
    @(negedge clk); op_valid = 0; inv_op = 0; inv_asid = 0; inv_va = 0;
    #1 checks++;
    if (inv_go !== 1 || f_op !== 5 || f_asid !== 10'h3A || f_va !== 19'h12345)
      begin errors++; $display("FAIL inv_go: inv_go=%b f_op=%0d f_asid=%h f_va=%h want 1 5 3a 12345", inv_go, f_op, f_asid, f_va); end
    @(negedge clk); #1 checks++;
    if (refetch !== 1) begin errors++; $display("FAIL inv_refetch: refetch=%b want 1", refetch); end
  endtask

  task automatic test_flush();
    @(negedge clk); op_valid = 1; op_type = 1;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (rd_go !== 1) begin errors++; $display("FAIL flush_rd_go: rd_go=%b want 1", rd_go); end
    @(negedge clk); flush_in = 1;
    #1 checks++;
    if (csr_re !== 0 || sv[9:2] !== 0) begin errors++; $display("FAIL flush_rcap: csr_re=%b sv=%b want strobes 0", csr_re, sv); end
    @(negedge clk); flush_in = 0;
    #1 checks++;
    if (busy !== 0 || refetch !== 0 || op_ready !== 1)
      begin errors++; $display("FAIL flush_abandon: busy=%b refetch=%b ready=%b want 0 0 1", busy, refetch, op_ready); end
    @(negedge clk); op_valid = 1; op_type = 2; flush_in = 1;
    #1 checks++;
    if (op_ready !== 0) begin errors++; $display("FAIL flush_idle_ready: op_ready=%b want 0", op_ready); end
    @(negedge clk); op_valid = 0; flush_in = 0;
    #1 checks++;
    if (busy !== 0 || tlb_we !== 0) begin errors++; $display("FAIL flush_idle_accept: busy=%b we=%b want 0 0", busy, tlb_we); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); op_valid = 1; op_type = 0;
    @(negedge clk); op_valid = 0;
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    #1 checks++;
    if (sv[9:1] !== 0 || csr_s1_index !== 0 || csr_s1_ne !== 0 || f_op !== 0)
      begin errors++; $display("FAIL reset_mid: sv=%b idx=%0d ne=%b f_op=%0d want zeros", sv, csr_s1_index, csr_s1_ne, f_op); end
    op_valid = 1; op_type = 3;
    @(negedge clk); op_valid = 0;
    #1 checks++;
    if (tlb_we !== 1 || tlb_w_index !== 0) begin errors++; $display("FAIL reset_fillcnt: we=%b idx=%0d want 1 0", tlb_we, tlb_w_index); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      int op, iop, fidx, lat;
      logic [9:0] asid, ev;
      logic [18:0] va;
      op = $urandom_range(0, 7);
      iop = (op == 4 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : $urandom_range(0, 31);
      asid = 10'($urandom);
      va = 19'($urandom);
      lat = op_lat(op, iop);
      @(negedge clk); op_valid = 1; op_type = 3'(op); inv_op = 5'(iop); inv_asid = asid; inv_va = va;
      #1 checks++;
      if (op_ready !== 1) begin errors++; $display("FAIL rnd_accept: op=%0d op_ready=%b want 1", op, op_ready); end
      fidx = model_cnt;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        op_valid = is_illegal(op, iop) ? 1'b0 : 1'($urandom);
        op_type = 3'($urandom); inv_op = 5'($urandom); inv_asid = 10'($urandom); inv_va = 19'($urandom);
        srch_hit = 1'($urandom); srch_index = 4'($urandom); csr_tlbidx = 4'($urandom);
        #1 ev = exp_sv(op, iop, k);
        checks++;
        if (sv !== ev) begin errors++; $display("FAIL rnd_strobes: op=%0d k=%0d sv=%b want %b", op, k, sv, ev); end
        checks++;
        if (csr_s1_index !== (ev[7] ? srch_index : 4'd0) || csr_s1_ne !== (ev[7] && !srch_hit) ||
            tlb_w_index !== (!ev[5] ? 4'd0 : op == 3 ? 4'(fidx) : csr_tlbidx))
          begin errors++; $display("FAIL rnd_index: op=%0d k=%0d s1idx=%0d ne=%b widx=%0d fidx=%0d", op, k, csr_s1_index, csr_s1_ne, tlb_w_index, fidx); end
        checks++;
        if (f_op !== 5'(iop) || f_asid !== asid || f_va !== va)
          begin errors++; $display("FAIL rnd_operands: f=%0d/%h/%h want %0d/%h/%h", f_op, f_asid, f_va, iop, asid, va); end
      end
    end
    op_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_srch();
    test_fill();
    test_wr();
    test_inv();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
